draw_sprite_keyed: RTL and testbench
====================================

// Module: draw_sprite_keyed
// PURPOSE
//  Parametrised sprite overlay stage in the VGA timing chain. Overlays a WxH texture from an external sync ROM
//  onto rgb_in, at a position latched once per frame. ROM latency and address split are parameters.
//  Pixels equal to a colour key pass rgb_in through. Timing signals are delayed to match the pixel path.
// PARAMETERS
//  RECT_WIDTH   48      sprite width in pixels (1..2^ADDR_X_BITS)
//  RECT_HEIGHT  64      sprite height in pixels (1..2^ADDR_Y_BITS)
//  ADDR_X_BITS  6       column bits of pixel_addr
//  ADDR_Y_BITS  6       row bits of pixel_addr; ADDR_W = ADDR_X_BITS+ADDR_Y_BITS
//  ROM_LATENCY  1       cycles from pixel_addr to valid rgb_pixel (1..4)
//  KEY_EN       1       1: colour-key transparency active; 0: every in-rect pixel drawn
//  KEY_RGB      12'hF0F transparent colour
// PORTS
//  pclk        in   1      pixel clock, all logic on rising edge
//  rst         in   1      synchronous reset, active high
//  hcount_in   in   11     horizontal count
//  hsync_in    in   1      horizontal sync
//  hblnk_in    in   1      horizontal blank
//  vcount_in   in   11     vertical count
//  vsync_in    in   1      vertical sync
//  vblnk_in    in   1      vertical blank
//  rgb_in      in   12     background colour
//  xpos        in   12     requested sprite left edge
//  ypos        in   12     requested sprite top edge
//  enable      in   1      requested sprite visibility
//  mirror_x    in   1      requested horizontal flip (used only with DRAW_SPRITE_MIRROR_EN)
//  rgb_pixel   in   12     texture data from ROM
//  pixel_addr  out  ADDR_W ROM address {row, col}
//  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  delayed timing
//  rgb_out     out  12     composited colour
// BEHAVIOUR
//  - Reset: rst synchronous, active high; all outputs, pipeline stages, latched regs <= 0 (enable_q=0: nothing drawn).
//  - Frame latch: xpos_q/ypos_q/enable_q/mirror_q load from inputs only on the cycle vblnk_in rises (vblnk_in=1, prev=0);
//    otherwise hold. Mid-frame input changes have no effect until next vblank rise. Edge detector reg resets to 0.
//  - Inside test, half-open, 13-bit unsigned (no wrap):
//    in = enable_q & hcount_in>=xpos_q & hcount_in<xpos_q+RECT_WIDTH & vcount_in>=ypos_q & vcount_in<ypos_q+RECT_HEIGHT.
//    Sprite partly past 2^11 is clipped, never wraps to column 0.
//  - Stage 1 (cycle after input): pixel_addr <= in ? {dy[ADDR_Y_BITS-1:0], dx[ADDR_X_BITS-1:0]} : 0;
//    dx = hcount_in-xpos_q, dy = vcount_in-ypos_q (12-bit).
//  - ROM delivers rgb_pixel ROM_LATENCY cycles after pixel_addr; `in` and rgb_in delayed ROM_LATENCY+1 with it.
//  - Output stage: rgb_out <= (in_d & !(KEY_EN & rgb_pixel==KEY_RGB)) ? rgb_pixel : rgb_in_d.
//  - Total latency LATENCY = ROM_LATENCY+2 for every output; all six timing signals delayed exactly LATENCY via shift regs.
//  - Blanking not forced: rgb during blank follows same rule (upstream guarantees rect within active area).
//  - Reset mid-frame: pipeline flushed to 0; drawing resumes only after next vblank rise latches enable.
// CONFIGURATION
//  DRAW_SPRITE_MIRROR_EN defined: dx replaced by RECT_WIDTH-1-(hcount_in-xpos_q) when mirror_q=1.
//  Not defined: mirror_x port present but ignored, mirror_q logic absent, dx never mirrored.
// TESTING
//  1 Reset: rst=1 two cycles -> all outputs 0; release, no vblank rise, enable=1 -> rgb_out==rgb_in delayed 3.
//  2 Latency: defaults, after vblank rise with x=100,y=50,enable=1; ROM model lat 1 -> hcount_out==hcount_in 3 cycles
//    earlier; at h=100,v=50 pixel_addr=0 next cycle; h=147,v=113 -> addr {6'd63,6'd47}; h=148 or v=114 -> rgb_in.
//  3 Latch: change xpos 100->200 at v=300 -> sprite still at 100 this frame, at 200 after next vblank rise.
//  4 Key: ROM returns 12'hF0F for col 5 -> rgb_out=rgb_in there; KEY_EN=0 build -> 12'hF0F drawn.
//  5 Clip: x=2040,W=48 -> drawn h 2040..2047 only, nothing at h 0..39; ROM_LATENCY=3 build -> latency 5 everywhere.
//  6 Mirror (DRAW_SPRITE_MIRROR_EN, mirror_x=1 latched): h=x -> col 47, h=x+47 -> col 0; macro undefined -> col 0, 47.

Source files
------------

// File: rtl/draw_sprite_keyed.sv
`default_nettype none
// ============================================================================
// Module  : draw_sprite_keyed
// Purpose : Colour-keyed sprite overlay stage for the VGA timing chain.
//           Optional horizontal flip when DRAW_SPRITE_MIRROR_EN is defined.
// Rev     : 1.0
// ============================================================================
module draw_sprite_keyed #(
  parameter int          RECT_WIDTH  = 48,
  parameter int          RECT_HEIGHT = 64,
  parameter int          ADDR_X_BITS = 6,
  parameter int          ADDR_Y_BITS = 6,
  parameter int          ROM_LATENCY = 1,
  parameter bit          KEY_EN      = 1'b1,
  parameter logic [11:0] KEY_RGB     = 12'hF0F
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic [10:0]                      hcount_in,
  input  logic                             hsync_in,
  input  logic                             hblnk_in,
  input  logic [10:0]                      vcount_in,
  input  logic                             vsync_in,
  input  logic                             vblnk_in,
  input  logic [11:0]                      rgb_in,
  input  logic [11:0]                      xpos,
  input  logic [11:0]                      ypos,
  input  logic                             enable,
  input  logic                             mirror_x,
  input  logic [11:0]                      rgb_pixel,
  output logic [ADDR_X_BITS+ADDR_Y_BITS-1:0] pixel_addr,
  output logic [10:0]                      hcount_out,
  output logic                             hsync_out,
  output logic                             hblnk_out,
  output logic [10:0]                      vcount_out,
  output logic                             vsync_out,
  output logic                             vblnk_out,
  output logic [11:0]                      rgb_out
);

  localparam int c_ADDR_W  = ADDR_X_BITS + ADDR_Y_BITS;
  localparam int c_LATENCY = ROM_LATENCY + 2;
  localparam int c_TIM_W   = 26;

  logic        r_vblnk_prev;
  logic [11:0] r_xpos;
  logic [11:0] r_ypos;
  logic        r_enable;
  logic        w_vblnk_rise;

  assign w_vblnk_rise = vblnk_in & ~r_vblnk_prev;

  // Position and visibility only change at the start of vertical blank
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_xpos       <= '0;
      r_ypos       <= '0;
      r_enable     <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vblnk_rise) begin
        r_xpos   <= xpos;
        r_ypos   <= ypos;
        r_enable <= enable;
      end
    end
  end

  // 13-bit compare so a sprite hanging past column 2047 clips instead of wrapping
  logic [12:0] w_h;
  logic [12:0] w_v;
  logic [12:0] w_x;
  logic [12:0] w_y;
  logic        w_in;

  assign w_h  = {2'b00, hcount_in};
  assign w_v  = {2'b00, vcount_in};
  assign w_x  = {1'b0, r_xpos};
  assign w_y  = {1'b0, r_ypos};
  assign w_in = r_enable
             && (w_h >= w_x) && (w_h < w_x + 13'(RECT_WIDTH))
             && (w_v >= w_y) && (w_v < w_y + 13'(RECT_HEIGHT));

  logic [11:0] w_dx_raw;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic        w_unused;

  assign w_dx_raw = {1'b0, hcount_in} - r_xpos;
  assign w_dy     = {1'b0, vcount_in} - r_ypos;

`ifdef DRAW_SPRITE_MIRROR_EN
  logic r_mirror;

  always_ff @(posedge pclk) begin
    if (rst)
      r_mirror <= 1'b0;
    else if (w_vblnk_rise)
      r_mirror <= mirror_x;
  end

  assign w_dx     = r_mirror ? (12'(RECT_WIDTH - 1) - w_dx_raw) : w_dx_raw;
  assign w_unused = &{1'b0, w_dx[11:ADDR_X_BITS], w_dy[11:ADDR_Y_BITS]};
`else
  assign w_dx     = w_dx_raw;
  assign w_unused = &{1'b0, mirror_x, w_dx[11:ADDR_X_BITS], w_dy[11:ADDR_Y_BITS]};
`endif

  logic [c_ADDR_W-1:0] r_pixel_addr;
  logic                r_in_pipe  [0:ROM_LATENCY];
  logic [11:0]         r_rgb_pipe [0:ROM_LATENCY];
  logic [c_TIM_W-1:0]  r_tim_pipe [0:c_LATENCY-1];
  logic [11:0]         r_rgb_out;
  logic                w_key_hit;

  assign w_key_hit = KEY_EN && (rgb_pixel == KEY_RGB);

  // in/rgb_in ride alongside the ROM access so they line up with rgb_pixel
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_pixel_addr <= '0;
      r_rgb_out    <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        r_in_pipe[i]  <= 1'b0;
        r_rgb_pipe[i] <= '0;
      end
      for (int i = 0; i < c_LATENCY; i++)
        r_tim_pipe[i] <= '0;
    end else begin
      r_pixel_addr  <= w_in ? {w_dy[ADDR_Y_BITS-1:0], w_dx[ADDR_X_BITS-1:0]} : '0;
      r_in_pipe[0]  <= w_in;
      r_rgb_pipe[0] <= rgb_in;
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        r_in_pipe[i]  <= r_in_pipe[i-1];
        r_rgb_pipe[i] <= r_rgb_pipe[i-1];
      end
      r_tim_pipe[0] <= {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
      for (int i = 1; i < c_LATENCY; i++)
        r_tim_pipe[i] <= r_tim_pipe[i-1];
      r_rgb_out <= (r_in_pipe[ROM_LATENCY] && !w_key_hit) ? rgb_pixel
                                                          : r_rgb_pipe[ROM_LATENCY];
    end
  end

  assign pixel_addr = r_pixel_addr;
  assign rgb_out    = r_rgb_out;
  assign {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} =
         r_tim_pipe[c_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite_keyed.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_sprite_keyed
// Purpose : Scoreboard bench for draw_sprite_keyed: default build (latency 3,
//           keyed) and a ROM_LATENCY=3 / KEY_EN=0 build side by side.
// Rev     : 1.0
// ============================================================================
module tb_draw_sprite_keyed;

  localparam logic [11:0] c_KEY = 12'hF0F;
  localparam int          c_W   = 48;
  localparam int          c_H   = 64;

  typedef struct {
    int          due;
    logic [37:0] val;
  } exp_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        rst;
  logic [10:0] hcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic [10:0] vcount_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        enable;
  logic        mirror_x;

  logic [11:0] rgb_pixel_a, rgb_pixel_b, pixel_addr_a, pixel_addr_b;
  logic [10:0] hcount_out_a, vcount_out_a, hcount_out_b, vcount_out_b;
  logic        hsync_out_a, hblnk_out_a, vsync_out_a, vblnk_out_a;
  logic        hsync_out_b, hblnk_out_b, vsync_out_b, vblnk_out_b;
  logic [11:0] rgb_out_a, rgb_out_b;

  draw_sprite_keyed dut_a (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .enable(enable),
    .mirror_x(mirror_x), .rgb_pixel(rgb_pixel_a), .pixel_addr(pixel_addr_a),
    .hcount_out(hcount_out_a), .hsync_out(hsync_out_a), .hblnk_out(hblnk_out_a),
    .vcount_out(vcount_out_a), .vsync_out(vsync_out_a), .vblnk_out(vblnk_out_a),
    .rgb_out(rgb_out_a)
  );

  draw_sprite_keyed #(.ROM_LATENCY(3), .KEY_EN(1'b0)) dut_b (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .enable(enable),
    .mirror_x(mirror_x), .rgb_pixel(rgb_pixel_b), .pixel_addr(pixel_addr_b),
    .hcount_out(hcount_out_b), .hsync_out(hsync_out_b), .hblnk_out(hblnk_out_b),
    .vcount_out(vcount_out_b), .vsync_out(vsync_out_b), .vblnk_out(vblnk_out_b),
    .rgb_out(rgb_out_b)
  );

  // Texture: column 5 carries the key colour, everything else a scrambled address
  function automatic logic [11:0] tex(input logic [11:0] a);
    if (a[5:0] == 6'd5) return c_KEY;
    return a ^ 12'h5A3;
  endfunction

  logic [11:0] rom_b [0:2];
  always @(posedge pclk) begin
    rgb_pixel_a <= tex(pixel_addr_a);
    rom_b[0]    <= tex(pixel_addr_b);
    rom_b[1]    <= rom_b[0];
    rom_b[2]    <= rom_b[1];
  end
  assign rgb_pixel_b = rom_b[2];

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  exp_t q_a[$], q_b[$], qa_a[$], qa_b[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the sprite registers should hold this frame
  bit m_prev, m_en, m_mir;
  int m_x, m_y;

  task automatic model_step();
    exp_t        e;
    int          h, v, dx, dy;
    bit          ins;
    logic [11:0] a, t;
    logic [25:0] tim;
    if (rst) begin
      // Everything already in flight is wiped by the reset edge
      for (int i = 0; i < q_a.size(); i++) begin e = q_a[i]; e.val = '0; q_a[i] = e; end
      for (int i = 0; i < q_b.size(); i++) begin e = q_b[i]; e.val = '0; q_b[i] = e; end
      e.val = '0;
      e.due = cyc + 3; q_a.push_back(e);
      e.due = cyc + 5; q_b.push_back(e);
      e.due = cyc + 1; qa_a.push_back(e); qa_b.push_back(e);
      m_prev = 0; m_en = 0; m_mir = 0; m_x = 0; m_y = 0;
    end else begin
      h   = int'(hcount_in);
      v   = int'(vcount_in);
      ins = m_en && h >= m_x && h < m_x + c_W && v >= m_y && v < m_y + c_H;
      dx  = h - m_x;
      dy  = v - m_y;
`ifdef DRAW_SPRITE_MIRROR_EN
      if (m_mir) dx = c_W - 1 - dx;
`endif
      a   = ins ? 12'(dy * 64 + dx) : 12'd0;
      t   = tex(a);
      tim = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
      e.due = cyc + 3; e.val = {tim, (ins && t != c_KEY) ? t : rgb_in}; q_a.push_back(e);
      e.due = cyc + 5; e.val = {tim, ins ? t : rgb_in};                 q_b.push_back(e);
      e.due = cyc + 1; e.val = 38'(a); qa_a.push_back(e); qa_b.push_back(e);
      if (vblnk_in && !m_prev) begin
        m_x = int'(xpos); m_y = int'(ypos); m_en = enable; m_mir = mirror_x;
      end
      m_prev = vblnk_in;
    end
  endtask

  task automatic drive(input bit r, input int h, input int v, input bit vb,
                       input int x, input int y, input bit en, input bit mir);
    @(negedge pclk);
    rst       = r;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = 1'($urandom);
    hblnk_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    vblnk_in  = vb;
    rgb_in    = 12'($urandom);
    xpos      = 12'(x);
    ypos      = 12'(y);
    enable    = en;
    mirror_x  = mir;
    model_step();
  endtask

  task automatic rise(input int x, input int y, input bit en, input bit mir);
    drive(0, 0, 0, 0, x, y, en, mir);
    drive(0, 0, 0, 1, x, y, en, mir);
  endtask

  task automatic scan(input int x, input int y, input int xi, input int yi,
                      input bit en, input bit mir);
    for (int v = y - 1; v <= y + c_H; v++)
      for (int h = x - 2; h <= x + c_W + 1; h++)
        drive(0, h & 2047, v & 2047, 0, xi, yi, en, mir);
  endtask

  logic [37:0] act_a, act_b;
  assign act_a = {hcount_out_a, hsync_out_a, hblnk_out_a, vcount_out_a, vsync_out_a, vblnk_out_a, rgb_out_a};
  assign act_b = {hcount_out_b, hsync_out_b, hblnk_out_b, vcount_out_b, vsync_out_b, vblnk_out_b, rgb_out_b};

  exp_t me;
  always @(posedge pclk) begin
    #1;
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      me = q_a.pop_front(); checks++;
      if (act_a !== me.val) begin
        errors++;
        $display("FAIL out_lat3 cyc=%0d got=%h expected=%h", cyc, act_a, me.val);
      end
    end
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      me = q_b.pop_front(); checks++;
      if (act_b !== me.val) begin
        errors++;
        $display("FAIL out_lat5_nokey cyc=%0d got=%h expected=%h", cyc, act_b, me.val);
      end
    end
    if (qa_a.size() > 0 && qa_a[0].due == cyc) begin
      me = qa_a.pop_front(); checks++;
      if (pixel_addr_a !== me.val[11:0]) begin
        errors++;
        $display("FAIL addr_a cyc=%0d got=%h expected=%h", cyc, pixel_addr_a, me.val[11:0]);
      end
    end
    if (qa_b.size() > 0 && qa_b[0].due == cyc) begin
      me = qa_b.pop_front(); checks++;
      if (pixel_addr_b !== me.val[11:0]) begin
        errors++;
        $display("FAIL addr_b cyc=%0d got=%h expected=%h", cyc, pixel_addr_b, me.val[11:0]);
      end
    end
  end

  initial begin
    int x, y, h, v;
    bit en, mir;
    rst = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
    vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0; xpos = '0; ypos = '0;
    enable = 1'b0; mirror_x = 1'b0;

    repeat (2) drive(1, 100, 50, 1, 100, 50, 1, 0);
    // Enabled at the inputs but never latched: pure pass-through
    for (int i = 0; i < 20; i++) drive(0, 96 + i, 50, 0, 100, 50, 1, 0);

    rise(100, 50, 1, 0);
    scan(100, 50, 100, 50, 1, 0);
    // Move requested mid-frame: must not show until the next vblank rise
    for (int i = 0; i < 10; i++) drive(0, 90 + i, 300, 0, 200, 50, 1, 1);
    scan(100, 50, 200, 50, 1, 1);
    rise(200, 50, 1, 1);
    scan(200, 50, 200, 50, 1, 1);

    // Right-edge clipping
    rise(2040, 10, 1, 0);
    for (int vv = 9; vv <= 12; vv++) begin
      for (int hh = 2030; hh <= 2047; hh++) drive(0, hh, vv, 0, 2040, 10, 1, 0);
      for (int hh = 0; hh <= 45; hh++)      drive(0, hh, vv, 0, 2040, 10, 1, 0);
    end

    // Mid-frame reset: nothing drawn until a fresh vblank rise
    drive(1, 120, 60, 0, 100, 50, 1, 0);
    scan(100, 50, 100, 50, 1, 0);
    rise(100, 50, 1, 0);
    scan(100, 50, 100, 50, 1, 0);

    rise(100, 50, 0, 0);
    for (int i = 0; i < 200; i++) drive(0, 100 + (i % 48), 50 + i / 48, 0, 100, 50, 0, 0);

    for (int f = 0; f < 150; f++) begin
      x   = int'($urandom_range(0, 2047));
      y   = int'($urandom_range(0, 2047));
      en  = ($urandom % 4) != 0;
      mir = 1'($urandom);
      rise(x, y, en, mir);
      for (int k = 0; k < 60; k++) begin
        h = (x + int'($urandom_range(0, 56)) - 4) & 2047;
        v = (y + int'($urandom_range(0, 72)) - 4) & 2047;
        drive(($urandom % 300) == 0, h, v, ($urandom % 16) == 0,
              int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
              1'($urandom), 1'($urandom));
      end
    end

    repeat (8) @(negedge pclk);
    checks++;
    if (q_a.size() + q_b.size() + qa_a.size() + qa_b.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0",
               q_a.size() + q_b.size() + qa_a.size() + qa_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
